ddr2_init_refresh_seq: RTL and testbench

//  Parametrised DDR2 power-up/mode-register sequencer plus refresh scheduler. Drives the

---
 rtl/ddr2_init_refresh_seq_pkg.sv | 62 ++++++
 rtl/ddr2_init_refresh_seq_if.sv | 33 +++
 rtl/ddr2_init_refresh_seq_refresh_sched.sv | 71 +++++++
 rtl/ddr2_init_refresh_seq.sv | 160 ++++++++++++++++
 tb/tb_ddr2_init_refresh_seq.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/ddr2_init_refresh_seq_pkg.sv
// Shared DDR2 command encodings, mode-register field positions and init FSM states
// for the power-up / refresh sequencer.
package ddr2_init_refresh_seq_pkg;

  typedef enum logic [2:0] {
    CMD_LOAD = 3'b000,
    CMD_REF  = 3'b001,
    CMD_PRE  = 3'b010,
    CMD_ACT  = 3'b011,
    CMD_WR   = 3'b100,
    CMD_RD   = 3'b101,
    CMD_NOP  = 3'b111
  } ddr2_cmd_e;

  typedef enum logic [3:0] {
    ST_W200,
    ST_PREA1,
    ST_EMR2,
    ST_EMR3,
    ST_EMR1,
    ST_MRDLL,
    ST_PREA2,
    ST_REF1,
    ST_REF2,
    ST_MR,
    ST_OCDDEF,
    ST_OCDEXIT,
    ST_DLLW,
    ST_IDLE
  } init_state_e;

  localparam int MR_BL_LSB      = 0;
  localparam int MR_CL_LSB      = 4;
  localparam int MR_DLL_RST_BIT = 8;
  localparam int MR_WR_LSB      = 9;
  localparam int PRE_ALL_BIT    = 10;
  localparam int EMR_OCD_LSB    = 7;

  localparam int BA_MR   = 0;
  localparam int BA_EMR1 = 1;
  localparam int BA_EMR2 = 2;
  localparam int BA_EMR3 = 3;

  // A0=0 enables the DLL; drive strength, Rtt and AL all left at their zero defaults
  localparam logic [15:0] EMR1_BASE = 16'h0000;

  function automatic logic [15:0] mr_word(input int cl, input int wr, input int bl);
    logic [15:0] w;
    int          wr_m1;
    w     = '0;
    wr_m1 = wr - 1;
    w[MR_BL_LSB +: 3] = (bl == 8) ? 3'b011 : 3'b010;
    w[MR_CL_LSB +: 3] = cl[2:0];
    w[MR_WR_LSB +: 3] = wr_m1[2:0];
    return w;
  endfunction

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ddr2_init_refresh_seq_if.sv
// DRAM command pins plus the refresh req/gnt handshake with the main command arbiter.
interface ddr2_init_refresh_seq_if #(
  parameter int ADDR_BITS = 14,
  parameter int BA_BITS   = 3,
  parameter int CS_BITS   = 1
);
  logic [CS_BITS-1:0]   cke;
  logic [CS_BITS-1:0]   cs_n;
  logic                 ras_n;
  logic                 cas_n;
  logic                 we_n;
  logic [BA_BITS-1:0]   ba;
  logic [ADDR_BITS-1:0] addr;
  logic [CS_BITS-1:0]   odt;
  logic                 init_done;
  logic                 ref_req;
  logic                 ref_urgent;
  logic                 ref_gnt;
  logic                 ref_busy;
  logic                 cmd_own;

  modport master (
    output cke, cs_n, ras_n, cas_n, we_n, ba, addr, odt,
    output init_done, ref_req, ref_urgent, ref_busy, cmd_own,
    input  ref_gnt
  );

  modport slave (
    input  cke, cs_n, ras_n, cas_n, we_n, ba, addr, odt,
    input  init_done, ref_req, ref_urgent, ref_busy, cmd_own,
    output ref_gnt
  );
endinterface

// File: rtl/ddr2_init_refresh_seq_refresh_sched.sv
// Refresh scheduler: tREFI interval ticker, saturating owed-refresh counter and the
// req/gnt/busy handshake that holds the bus for tRFC after each REF.
module ddr2_init_refresh_seq_refresh_sched #(
  parameter int T_RFC_CYC    = 17,
  parameter int T_REFI_CYC   = 1036,
  parameter int MAX_POSTPONE = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic ref_gnt,
  output logic ref_req,
  output logic ref_urgent,
  output logic ref_busy,
  output logic ref_start
);

  localparam int REFI_W = $clog2(T_REFI_CYC + 1);
  localparam int RFC_W  = $clog2(T_RFC_CYC + 1);
  localparam int OWED_W = $clog2(MAX_POSTPONE + 2);

  localparam logic [REFI_W-1:0] REFI_RELOAD = REFI_W'(T_REFI_CYC - 1);
  localparam logic [RFC_W-1:0]  RFC_LOAD    = RFC_W'(T_RFC_CYC - 1);
  localparam logic [OWED_W-1:0] OWED_SAT    = OWED_W'(MAX_POSTPONE + 1);
  localparam logic [OWED_W-1:0] OWED_URGENT = OWED_W'(MAX_POSTPONE);

  logic [REFI_W-1:0] refi_cnt;
  logic [RFC_W-1:0]  rfc_cnt;
  logic [OWED_W-1:0] owed;
  logic [OWED_W-1:0] owed_nxt;
  logic              busy_nxt;
  logic              tick;
  logic              done;

  assign tick      = run && (refi_cnt == '0);
  assign done      = ref_busy && (rfc_cnt == '0);
  assign ref_start = run && ref_gnt && ref_req;

  // A tick and a completed refresh in the same cycle cancel out
  always_comb begin
    owed_nxt = owed;
    busy_nxt = ref_busy;
    if (tick && !done) begin
      if (owed != OWED_SAT) owed_nxt = owed + 1'b1;
    end else if (done && !tick) begin
      owed_nxt = owed - 1'b1;
    end
    if (ref_start) busy_nxt = 1'b1;
    else if (done) busy_nxt = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst || !run) begin
      refi_cnt   <= REFI_RELOAD;
      rfc_cnt    <= '0;
      owed       <= '0;
      ref_busy   <= 1'b0;
      ref_req    <= 1'b0;
      ref_urgent <= 1'b0;
    end else begin
      refi_cnt <= tick ? REFI_RELOAD : refi_cnt - 1'b1;
      if (ref_start) rfc_cnt <= RFC_LOAD;
      else if (ref_busy && rfc_cnt != '0) rfc_cnt <= rfc_cnt - 1'b1;
      owed       <= owed_nxt;
      ref_busy   <= busy_nxt;
      ref_req    <= (owed_nxt != '0) && !busy_nxt;
      ref_urgent <= (owed_nxt >= OWED_URGENT);
    end
  end

endmodule

// File: rtl/ddr2_init_refresh_seq.sv
// DDR2 power-up / mode-register sequencer; after init it hands the pins to the
// refresh scheduler, which issues auto-refresh on grant from the command arbiter.
module ddr2_init_refresh_seq
  import ddr2_init_refresh_seq_pkg::*;
#(
  parameter int ADDR_BITS    = 14,
  parameter int BA_BITS      = 3,
  parameter int CS_BITS      = 1,
  parameter int T_INIT_CYC   = 26596,
  parameter int T_CKE_CYC    = 54,
  parameter int T_RP_CYC     = 3,
  parameter int T_MRD_CYC    = 2,
  parameter int T_RFC_CYC    = 17,
  parameter int T_REFI_CYC   = 1036,
  parameter int T_DLL_CYC    = 200,
  parameter int CL           = 5,
  parameter int WR           = 6,
  parameter int BL           = 4,
  parameter int MAX_POSTPONE = 8
) (
  input logic                     clk,
  input logic                     rst,
  ddr2_init_refresh_seq_if.master bus
);

  localparam int WAIT_MAX = imax(imax(imax(T_INIT_CYC, T_CKE_CYC), imax(T_RP_CYC, T_MRD_CYC)),
                                 imax(T_RFC_CYC, T_DLL_CYC));
  localparam int WAIT_W   = $clog2(WAIT_MAX + 1);

  localparam logic [ADDR_BITS-1:0] MR_VAL   = ADDR_BITS'(mr_word(CL, WR, BL));
  localparam logic [ADDR_BITS-1:0] DLL_RST  = ADDR_BITS'(32'd1 << MR_DLL_RST_BIT);
  localparam logic [ADDR_BITS-1:0] PRE_ALL  = ADDR_BITS'(32'd1 << PRE_ALL_BIT);
  localparam logic [ADDR_BITS-1:0] EMR1_VAL = ADDR_BITS'(EMR1_BASE);
  localparam logic [ADDR_BITS-1:0] OCD_DEF  = ADDR_BITS'(32'h7 << EMR_OCD_LSB);

  init_state_e          state, state_nxt;
  logic [WAIT_W-1:0]    wait_cnt, wait_nxt;
  logic                 cke_q, cke_nxt;
  ddr2_cmd_e            cmd_q, cmd_nxt;
  logic [BA_BITS-1:0]   ba_q, ba_nxt;
  logic [ADDR_BITS-1:0] addr_q, addr_nxt;
  logic                 done_q, done_nxt;
  logic                 go;
  logic                 ref_busy;
  logic                 ref_start;

  assign go = (wait_cnt == '0);

  ddr2_init_refresh_seq_refresh_sched #(
    .T_RFC_CYC    (T_RFC_CYC),
    .T_REFI_CYC   (T_REFI_CYC),
    .MAX_POSTPONE (MAX_POSTPONE)
  ) u_sched (
    .clk        (clk),
    .rst        (rst),
    .run        (done_q),
    .ref_gnt    (bus.ref_gnt),
    .ref_req    (bus.ref_req),
    .ref_urgent (bus.ref_urgent),
    .ref_busy   (ref_busy),
    .ref_start  (ref_start)
  );

  // Each init step fires once its wait has expired, then loads the gap to the next step
  always_comb begin
    state_nxt = state;
    wait_nxt  = go ? '0 : wait_cnt - 1'b1;
    cke_nxt   = cke_q;
    cmd_nxt   = CMD_NOP;
    ba_nxt    = '0;
    addr_nxt  = '0;
    done_nxt  = done_q;
    case (state)
      ST_W200: if (go) begin
        cke_nxt = 1'b1; wait_nxt = WAIT_W'(T_CKE_CYC - 1); state_nxt = ST_PREA1;
      end
      ST_PREA1: if (go) begin
        cmd_nxt = CMD_PRE; addr_nxt = PRE_ALL;
        wait_nxt = WAIT_W'(T_RP_CYC - 1); state_nxt = ST_EMR2;
      end
      ST_EMR2: if (go) begin
        cmd_nxt = CMD_LOAD; ba_nxt = BA_BITS'(BA_EMR2);
        wait_nxt = WAIT_W'(T_MRD_CYC - 1); state_nxt = ST_EMR3;
      end
      ST_EMR3: if (go) begin
        cmd_nxt = CMD_LOAD; ba_nxt = BA_BITS'(BA_EMR3);
        wait_nxt = WAIT_W'(T_MRD_CYC - 1); state_nxt = ST_EMR1;
      end
      ST_EMR1: if (go) begin
        cmd_nxt = CMD_LOAD; ba_nxt = BA_BITS'(BA_EMR1); addr_nxt = EMR1_VAL;
        wait_nxt = WAIT_W'(T_MRD_CYC - 1); state_nxt = ST_MRDLL;
      end
      ST_MRDLL: if (go) begin
        cmd_nxt = CMD_LOAD; ba_nxt = BA_BITS'(BA_MR); addr_nxt = MR_VAL | DLL_RST;
        wait_nxt = WAIT_W'(T_MRD_CYC - 1); state_nxt = ST_PREA2;
      end
      ST_PREA2: if (go) begin
        cmd_nxt = CMD_PRE; addr_nxt = PRE_ALL;
        wait_nxt = WAIT_W'(T_RP_CYC - 1); state_nxt = ST_REF1;
      end
      ST_REF1: if (go) begin
        cmd_nxt = CMD_REF; wait_nxt = WAIT_W'(T_RFC_CYC - 1); state_nxt = ST_REF2;
      end
      ST_REF2: if (go) begin
        cmd_nxt = CMD_REF; wait_nxt = WAIT_W'(T_RFC_CYC - 1); state_nxt = ST_MR;
      end
      ST_MR: if (go) begin
        cmd_nxt = CMD_LOAD; ba_nxt = BA_BITS'(BA_MR); addr_nxt = MR_VAL;
        wait_nxt = WAIT_W'(T_MRD_CYC - 1); state_nxt = ST_OCDDEF;
      end
      ST_OCDDEF: if (go) begin
        cmd_nxt = CMD_LOAD; ba_nxt = BA_BITS'(BA_EMR1); addr_nxt = EMR1_VAL | OCD_DEF;
        wait_nxt = WAIT_W'(T_MRD_CYC - 1); state_nxt = ST_OCDEXIT;
      end
      ST_OCDEXIT: if (go) begin
        cmd_nxt = CMD_LOAD; ba_nxt = BA_BITS'(BA_EMR1); addr_nxt = EMR1_VAL;
        wait_nxt = WAIT_W'(T_DLL_CYC - 1); state_nxt = ST_DLLW;
      end
      ST_DLLW: if (go) begin
        done_nxt = 1'b1; state_nxt = ST_IDLE;
      end
      ST_IDLE: if (ref_start) cmd_nxt = CMD_REF;
      default: state_nxt = ST_W200;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_W200;
      wait_cnt <= WAIT_W'(T_INIT_CYC - 1);
      cke_q    <= 1'b0;
      cmd_q    <= CMD_NOP;
      ba_q     <= '0;
      addr_q   <= '0;
      done_q   <= 1'b0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_nxt;
      cke_q    <= cke_nxt;
      cmd_q    <= cmd_nxt;
      ba_q     <= ba_nxt;
      addr_q   <= addr_nxt;
      done_q   <= done_nxt;
    end
  end

  // Every rank is addressed together, so chip select stays asserted; NOPs mask the gaps
  assign bus.cke       = {CS_BITS{cke_q}};
  assign bus.cs_n      = '0;
  assign bus.odt       = '0;
  assign bus.ras_n     = cmd_q[2];
  assign bus.cas_n     = cmd_q[1];
  assign bus.we_n      = cmd_q[0];
  assign bus.ba        = ba_q;
  assign bus.addr      = addr_q;
  assign bus.init_done = done_q;
  assign bus.ref_busy  = ref_busy;
  assign bus.cmd_own   = !done_q || ref_busy;

endmodule

// File: tb/tb_ddr2_init_refresh_seq.sv
// Directed bench for the DDR2 init/refresh sequencer: expected commands are queued with
// their issue cycle and checked as they appear on the pins.
module tb_ddr2_init_refresh_seq;

  localparam int T_INIT = 20;
  localparam int T_CKE  = 4;
  localparam int T_RP   = 3;
  localparam int T_MRD  = 2;
  localparam int T_RFC  = 10;
  localparam int T_REFI = 100;
  localparam int T_DLL  = 8;

  localparam int C_LOAD = 0;
  localparam int C_REF  = 1;
  localparam int C_PRE  = 2;
  localparam int C_NOP  = 7;

  typedef struct {
    int cmd;
    int ba;
    int addr;
    int cyc;
  } exp_t;

  logic clk;
  logic rst;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  ddr2_init_refresh_seq_if #(.ADDR_BITS(14), .BA_BITS(3), .CS_BITS(1)) bus ();

  ddr2_init_refresh_seq #(
    .ADDR_BITS(14), .BA_BITS(3), .CS_BITS(1),
    .T_INIT_CYC(T_INIT), .T_CKE_CYC(T_CKE), .T_RP_CYC(T_RP), .T_MRD_CYC(T_MRD),
    .T_RFC_CYC(T_RFC), .T_REFI_CYC(T_REFI), .T_DLL_CYC(T_DLL),
    .CL(5), .WR(6), .BL(4), .MAX_POSTPONE(8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic g);
    rst         = r;
    bus.ref_gnt = g;
  endtask

  task automatic pushCmd(input int c, input int b, input int a, input int t);
    exp_t e;
    e.cmd = c; e.ba = b; e.addr = a; e.cyc = t;
    sb.push_back(e);
  endtask

  // Advance one cycle and score any command that appeared on the pins
  task automatic step();
    logic [2:0] cmdv;
    exp_t       e;
    @(negedge clk);
    cmdv = {bus.ras_n, bus.cas_n, bus.we_n};
    if (cmdv !== 3'b111) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected_cmd", 32'(cmdv), 32'(C_NOP));
      end else begin
        e = sb.pop_front();
        checkOutput("cmd_code", 32'(cmdv), 32'(e.cmd));
        checkOutput("cmd_ba", 32'(bus.ba), 32'(e.ba));
        checkOutput("cmd_addr", 32'(bus.addr), 32'(e.addr));
        checkOutput("cmd_cycle", 32'(cyc), 32'(e.cyc));
        checkOutput("cmd_cs_n", 32'(bus.cs_n), 32'd0);
        checkOutput("cmd_odt", 32'(bus.odt), 32'd0);
      end
    end
  endtask

  task automatic stepUntil(input int target);
    while (cyc < target) step();
  endtask

  // Releases reset, queues the 11 init commands and returns the expected init_done cycle
  task automatic runInit(output int d);
    int p, c, t;
    applyStimulus(1'b0, 1'b0);
    p = cyc + 1;
    c = p + T_INIT - 1;
    t = c + T_CKE;  pushCmd(C_PRE,  0, 14'h400, t);
    t += T_RP;      pushCmd(C_LOAD, 2, 0, t);
    t += T_MRD;     pushCmd(C_LOAD, 3, 0, t);
    t += T_MRD;     pushCmd(C_LOAD, 1, 0, t);
    t += T_MRD;     pushCmd(C_LOAD, 0, 14'hB52, t);
    t += T_MRD;     pushCmd(C_PRE,  0, 14'h400, t);
    t += T_RP;      pushCmd(C_REF,  0, 0, t);
    t += T_RFC;     pushCmd(C_REF,  0, 0, t);
    t += T_RFC;     pushCmd(C_LOAD, 0, 14'hA52, t);
    t += T_MRD;     pushCmd(C_LOAD, 1, 14'h380, t);
    t += T_MRD;     pushCmd(C_LOAD, 1, 0, t);
    d = t + T_DLL;
    while (bus.init_done !== 1'b1 && cyc < d + 10) begin
      step();
      checkOutput("init_cke", 32'(bus.cke), 32'(cyc >= c));
      checkOutput("init_ref_req", 32'(bus.ref_req), 32'd0);
      checkOutput("init_ref_busy", 32'(bus.ref_busy), 32'd0);
      checkOutput("init_cmd_own", 32'(bus.cmd_own), 32'(cyc < d));
      if (cyc == p + 3 || cyc == c + 8) applyStimulus(1'b0, 1'b1);
      else applyStimulus(1'b0, 1'b0);
    end
    applyStimulus(1'b0, 1'b0);
    checkOutput("init_done_cycle", 32'(cyc), 32'(d));
    checkOutput("init_sb_empty", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    int d, d2;
    applyStimulus(1'b1, 1'b0);
    repeat (3) step();
    checkOutput("rst_cke", 32'(bus.cke), 32'd0);
    checkOutput("rst_cmd", 32'({bus.ras_n, bus.cas_n, bus.we_n}), 32'(C_NOP));
    checkOutput("rst_ba_addr", 32'({bus.ba, bus.addr}), 32'd0);
    checkOutput("rst_odt", 32'(bus.odt), 32'd0);
    checkOutput("rst_init_done", 32'(bus.init_done), 32'd0);
    checkOutput("rst_urgent", 32'(bus.ref_urgent), 32'd0);
    checkOutput("rst_cmd_own", 32'(bus.cmd_own), 32'd1);

    runInit(d);

    // Grant while nothing is owed must be ignored
    stepUntil(d + 5);
    applyStimulus(1'b0, 1'b1);
    step();
    applyStimulus(1'b0, 1'b0);
    checkOutput("spur_busy", 32'(bus.ref_busy), 32'd0);
    checkOutput("spur_cmd_own", 32'(bus.cmd_own), 32'd0);
    stepUntil(d + 99);
    checkOutput("req_before_refi", 32'(bus.ref_req), 32'd0);
    step();
    checkOutput("req_at_refi", 32'(bus.ref_req), 32'd1);
    checkOutput("urgent_one_owed", 32'(bus.ref_urgent), 32'd0);
    applyStimulus(1'b0, 1'b1);
    pushCmd(C_REF, 0, 0, d + 101);
    step();
    applyStimulus(1'b0, 1'b0);
    checkOutput("single_busy_first", 32'(bus.ref_busy), 32'd1);
    checkOutput("single_cmd_own", 32'(bus.cmd_own), 32'd1);
    checkOutput("single_req_busy", 32'(bus.ref_req), 32'd0);
    stepUntil(d + 110);
    checkOutput("single_busy_last", 32'(bus.ref_busy), 32'd1);
    step();
    checkOutput("single_busy_end", 32'(bus.ref_busy), 32'd0);
    checkOutput("single_req_end", 32'(bus.ref_req), 32'd0);
    checkOutput("single_own_end", 32'(bus.cmd_own), 32'd0);

    // Eight postponed refreshes, then drained back-to-back
    stepUntil(d + 899);
    checkOutput("post_urgent_7", 32'(bus.ref_urgent), 32'd0);
    checkOutput("post_req_7", 32'(bus.ref_req), 32'd1);
    step();
    checkOutput("post_urgent_8", 32'(bus.ref_urgent), 32'd1);
    applyStimulus(1'b0, 1'b1);
    for (int i = 0; i < 8; i++) pushCmd(C_REF, 0, 0, d + 901 + 11 * i);
    stepUntil(d + 910);
    checkOutput("drain_urgent_hold", 32'(bus.ref_urgent), 32'd1);
    step();
    checkOutput("drain_urgent_drop", 32'(bus.ref_urgent), 32'd0);
    stepUntil(d + 987);
    checkOutput("drain_last_busy", 32'(bus.ref_busy), 32'd1);
    step();
    checkOutput("drain_req_zero", 32'(bus.ref_req), 32'd0);
    step();
    applyStimulus(1'b0, 1'b0);
    checkOutput("drain_gnt_ignored", 32'(bus.ref_busy), 32'd0);
    checkOutput("drain_sb_empty", 32'(sb.size()), 32'd0);

    // Saturate at 9 owed; drain so a completion lands on the tick at d+2100
    stepUntil(d + 2067);
    checkOutput("sat_urgent", 32'(bus.ref_urgent), 32'd1);
    checkOutput("sat_req", 32'(bus.ref_req), 32'd1);
    applyStimulus(1'b0, 1'b1);
    for (int i = 0; i < 10; i++) pushCmd(C_REF, 0, 0, d + 2068 + 11 * i);
    stepUntil(d + 2176);
    checkOutput("sat_last_busy", 32'(bus.ref_busy), 32'd1);
    step();
    checkOutput("sat_req_zero", 32'(bus.ref_req), 32'd0);
    applyStimulus(1'b0, 1'b0);
    step();
    checkOutput("sat_sb_empty", 32'(sb.size()), 32'd0);

    // Reset during tRFC aborts and restarts the whole init
    stepUntil(d + 2200);
    checkOutput("mid_req", 32'(bus.ref_req), 32'd1);
    applyStimulus(1'b0, 1'b1);
    pushCmd(C_REF, 0, 0, d + 2201);
    step();
    applyStimulus(1'b0, 1'b0);
    stepUntil(d + 2205);
    checkOutput("mid_busy5", 32'(bus.ref_busy), 32'd1);
    applyStimulus(1'b1, 1'b0);
    step();
    checkOutput("abort_cke", 32'(bus.cke), 32'd0);
    checkOutput("abort_cmd", 32'({bus.ras_n, bus.cas_n, bus.we_n}), 32'(C_NOP));
    checkOutput("abort_busy", 32'(bus.ref_busy), 32'd0);
    checkOutput("abort_init_done", 32'(bus.init_done), 32'd0);
    checkOutput("abort_req", 32'(bus.ref_req), 32'd0);
    checkOutput("abort_cmd_own", 32'(bus.cmd_own), 32'd1);
    step();
    step();
    runInit(d2);
    stepUntil(d2 + 20);
    checkOutput("reinit_req", 32'(bus.ref_req), 32'd0);
    checkOutput("reinit_own", 32'(bus.cmd_own), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
